// File: rtl/fp_acc_sram_loader_if.sv
// Bus bundle for the fp accumulator SRAM loader: operand stream, SRAM port,
// accumulator handshake and result port.
interface fp_acc_sram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  sram_write_enable;
  logic [ADDR_WIDTH-1:0] sram_write_address;
  logic [DATA_WIDTH-1:0] sram_write_data;
  logic [ADDR_WIDTH-1:0] sram_read_address;
  logic [DATA_WIDTH-1:0] sram_read_data;
  logic                  sram_sel;
  logic                  acc_valid;
  logic                  acc_ready;
  logic                  result_valid;
  logic                  result_ready;
  logic [DATA_WIDTH-1:0] result_data;
  logic [15:0]           result_count;
  logic                  result_trunc;
  logic                  busy;

  // Environment side: producer, SRAM, accumulator and result consumer.
  modport master (
    output in_valid, in_data, in_last, sram_read_data, acc_ready, result_ready,
    input  in_ready, sram_write_enable, sram_write_address, sram_write_data,
           sram_read_address, sram_sel, acc_valid, result_valid, result_data,
           result_count, result_trunc, busy
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, in_last, sram_read_data, acc_ready, result_ready,
    output in_ready, sram_write_enable, sram_write_address, sram_write_data,
           sram_read_address, sram_sel, acc_valid, result_valid, result_data,
           result_count, result_trunc, busy
  );
endinterface

// File: rtl/fp_acc_sram_loader.sv
// Builds the accumulator's SRAM image (count at ADDR_BASE, operands above it),
// hands the SRAM to the accumulator, then reads back the sum and returns it.
module fp_acc_sram_loader #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 16'h0000,
  parameter logic [15:0]           MAX_WORDS  = 16'hFFFD
) (
  input  logic                clk,
  input  logic                reset,
  fp_acc_sram_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_WCOUNT,
    S_START,
    S_RUN,
    S_RDREQ,
    S_RDWAIT,
    S_OUT
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic                  trunc_q, trunc_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [15:0]           res_count_q, res_count_d;
  logic                  res_trunc_q, res_trunc_d;

  logic [ADDR_WIDTH-1:0] slot_addr;
  logic                  accept;
  logic                  last_slot;

  // Address of the next operand slot; after loading it is where the sum lands.
  assign slot_addr = ADDR_BASE + ADDR_WIDTH'(count_q) + ADDR_WIDTH'(1);
  assign accept    = (state_q == S_LOAD) && bus.in_valid;
  assign last_slot = (count_q + 16'd1) == MAX_WORDS;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d                = state_q;
    count_d                = count_q;
    trunc_d                = trunc_q;
    res_data_d             = res_data_q;
    res_count_d            = res_count_q;
    res_trunc_d            = res_trunc_q;
    bus.in_ready           = 1'b0;
    bus.sram_write_enable  = 1'b0;
    bus.sram_write_address = '0;
    bus.sram_write_data    = '0;
    bus.sram_read_address  = '0;
    bus.sram_sel           = 1'b0;
    bus.acc_valid          = 1'b0;
    bus.result_valid       = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          bus.sram_write_enable  = 1'b1;
          bus.sram_write_address = slot_addr;
          bus.sram_write_data    = bus.in_data;
          count_d                = count_q + 16'd1;
          if (bus.in_last || last_slot) state_d = S_WCOUNT;
          if (!bus.in_last && last_slot) trunc_d = 1'b1;
        end
      end
      S_WCOUNT: begin
        bus.sram_write_enable  = 1'b1;
        bus.sram_write_address = ADDR_BASE;
        bus.sram_write_data    = DATA_WIDTH'(count_q);
        state_d                = S_START;
      end
      S_START: begin
        bus.sram_sel  = 1'b1;
        bus.acc_valid = 1'b1;
        // The accumulator drops ready once it has taken the request.
        if (!bus.acc_ready) state_d = S_RUN;
      end
      S_RUN: begin
        bus.sram_sel = 1'b1;
        if (bus.acc_ready) state_d = S_RDREQ;
      end
      S_RDREQ: begin
        bus.sram_read_address = slot_addr;
        state_d               = S_RDWAIT;
      end
      S_RDWAIT: begin
        res_data_d  = bus.sram_read_data;
        res_count_d = count_q;
        res_trunc_d = trunc_q;
        state_d     = S_OUT;
      end
      S_OUT: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) begin
          count_d = '0;
          trunc_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign bus.busy         = (state_q != S_LOAD);
  assign bus.result_data  = res_data_q;
  assign bus.result_count = res_count_q;
  assign bus.result_trunc = res_trunc_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_trunc_q <= res_trunc_d;
    end
  end

endmodule

// File: tb/tb_fp_acc_sram_loader.sv
// Directed bench for fp_acc_sram_loader: two instances (base 0 / MAX_WORDS 4,
// and base 0x100), each with an SRAM and a behavioural accumulator model.
module tb_fp_acc_sram_loader;

  localparam int          ACC_LAT  = 5;
  localparam logic [15:0] BASES [2] = '{16'h0000, 16'h0100};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]        in_valid, in_last, in_ready, we, sel, acc_valid, acc_ready;
  logic [1:0]        result_valid, result_ready, result_trunc, busy;
  logic [1:0][31:0]  in_data, wdata, rdata, result_data, acc_sum;
  logic [1:0][15:0]  waddr, raddr, result_count, last_raddr;
  logic [1:0]        we_sel_bad, range_bad;
  int                acc_cnt    [2];
  int                acc_starts [2];
  logic [31:0]       mem [2][512];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [15:0] MAXW = (g == 0) ? 16'd4 : 16'hFFFD;
    fp_acc_sram_loader_if bus ();
    assign bus.in_valid       = in_valid[g];
    assign bus.in_data        = in_data[g];
    assign bus.in_last        = in_last[g];
    assign bus.sram_read_data = rdata[g];
    assign bus.acc_ready      = acc_ready[g];
    assign bus.result_ready   = result_ready[g];
    assign in_ready[g]        = bus.in_ready;
    assign we[g]              = bus.sram_write_enable;
    assign waddr[g]           = bus.sram_write_address;
    assign wdata[g]           = bus.sram_write_data;
    assign raddr[g]           = bus.sram_read_address;
    assign sel[g]             = bus.sram_sel;
    assign acc_valid[g]       = bus.acc_valid;
    assign result_valid[g]    = bus.result_valid;
    assign result_data[g]     = bus.result_data;
    assign result_count[g]    = bus.result_count;
    assign result_trunc[g]    = bus.result_trunc;
    assign busy[g]            = bus.busy;

    fp_acc_sram_loader #(.ADDR_BASE(BASES[g]), .MAX_WORDS(MAXW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  // SRAM plus accumulator model: on a start it waits ACC_LAT cycles, then writes
  // the hand-computed sum to BASE+N+1, N taken from the count word in SRAM.
  initial begin
    we_sel_bad = '0;
    range_bad  = '0;
    last_raddr = '0;
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        acc_ready[g]  <= 1'b1;
        acc_cnt[g]    <= 0;
        acc_starts[g] <= 0;
        for (int i = 0; i < 512; i++) mem[g][i] <= '0;
      end else begin
        if (we[g]) begin
          mem[g][waddr[g][8:0]] <= wdata[g];
          if (sel[g]) we_sel_bad[g] <= 1'b1;
          if (waddr[g] < BASES[g] || waddr[g] > 16'd511) range_bad[g] <= 1'b1;
        end
        if (raddr[g] != 16'd0) last_raddr[g] <= raddr[g];
        if (acc_valid[g] && acc_ready[g]) begin
          acc_ready[g]  <= 1'b0;
          acc_cnt[g]    <= ACC_LAT;
          acc_starts[g] <= acc_starts[g] + 1;
        end else if (!acc_ready[g]) begin
          if (acc_cnt[g] > 1) acc_cnt[g] <= acc_cnt[g] - 1;
          else begin
            mem[g][9'(BASES[g] + mem[g][BASES[g][8:0]][15:0] + 16'd1)] <= acc_sum[g];
            acc_ready[g] <= 1'b1;
          end
        end
      end
      rdata[g] <= mem[g][raddr[g][8:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_word(input int s, input logic [31:0] d, input logic l);
    int n = 0;
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    in_last[s]  = l;
    while (!in_ready[s] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("in_ready_timeout", {31'd0, in_ready[s]}, 32'd1);
    else @(negedge clk);
    in_valid[s] = 1'b0;
    in_last[s]  = 1'b0;
  endtask

  task automatic wait_result(input int s);
    int n = 0;
    while (!result_valid[s] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("result_valid", {31'd0, result_valid[s]}, 32'd1);
  endtask

  task automatic take_result(input int s, input int hold, input logic [31:0] exp_data,
                             input logic [15:0] exp_cnt, input logic exp_trunc);
    check("result_data", result_data[s], exp_data);
    check("result_count", {16'd0, result_count[s]}, {16'd0, exp_cnt});
    check("result_trunc", {31'd0, result_trunc[s]}, {31'd0, exp_trunc});
    for (int i = 0; i < hold; i++) begin
      result_ready[s] = 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, result_valid[s]}, 32'd1);
      check("hold_data", result_data[s], exp_data);
      check("hold_in_ready", {31'd0, in_ready[s]}, 32'd0);
    end
    result_ready[s] = 1'b1;
    @(negedge clk);
    result_ready[s] = 1'b0;
    check("result_taken", {31'd0, result_valid[s]}, 32'd0);
    check("busy_after_take", {31'd0, busy[s]}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = '0;
    in_last      = '0;
    in_data      = '0;
    result_ready = '0;
    acc_sum      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check("rst_sel", {31'd0, sel[0]}, 32'd0);
    check("rst_acc_valid", {31'd0, acc_valid[0]}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid[0]}, 32'd0);
    check("rst_we", {31'd0, we[0]}, 32'd0);
    check("rst_result_data", result_data[0], 32'd0);
    check("rst_in_ready_b", {31'd0, in_ready[1]}, 32'd1);

    // Basic 3-word batch: 1 + 2 + 3 = 6.0
    acc_sum[0] = 32'h40C0_0000;
    send_word(0, 32'h3F80_0000, 1'b0);
    send_word(0, 32'h4000_0000, 1'b0);
    send_word(0, 32'h4040_0000, 1'b1);
    wait_result(0);
    check("t1_mem0", mem[0][0], 32'd3);
    check("t1_mem1", mem[0][1], 32'h3F80_0000);
    check("t1_mem2", mem[0][2], 32'h4000_0000);
    check("t1_mem3", mem[0][3], 32'h4040_0000);
    check("t1_mem4", mem[0][4], 32'h40C0_0000);
    check("t1_starts", acc_starts[0], 32'd1);
    check("t1_raddr", {16'd0, last_raddr[0]}, 32'd4);
    take_result(0, 0, 32'h40C0_0000, 16'd3, 1'b0);

    // Same batch with 2-cycle valid gaps and a 5-cycle result stall
    pulse_reset();
    send_word(0, 32'h3F80_0000, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("t2_gap_we", {31'd0, we[0]}, 32'd0);
    end
    send_word(0, 32'h4000_0000, 1'b0);
    repeat (2) @(negedge clk);
    send_word(0, 32'h4040_0000, 1'b1);
    wait_result(0);
    check("t2_mem0", mem[0][0], 32'd3);
    check("t2_mem1", mem[0][1], 32'h3F80_0000);
    check("t2_mem2", mem[0][2], 32'h4000_0000);
    check("t2_mem3", mem[0][3], 32'h4040_0000);
    take_result(0, 5, 32'h40C0_0000, 16'd3, 1'b0);

    // MAX_WORDS=4 truncation; words 5 and 6 wait and open the next batch
    pulse_reset();
    acc_sum[0] = 32'h4120_0000;
    send_word(0, 32'h3F80_0000, 1'b0);
    send_word(0, 32'h4000_0000, 1'b0);
    send_word(0, 32'h4040_0000, 1'b0);
    send_word(0, 32'h4080_0000, 1'b0);
    fork
      begin
        send_word(0, 32'h40A0_0000, 1'b0);
        send_word(0, 32'h40C0_0000, 1'b0);
      end
      begin
        wait_result(0);
        check("t3_mem0", mem[0][0], 32'd4);
        check("t3_mem4", mem[0][4], 32'h4080_0000);
        check("t3_raddr", {16'd0, last_raddr[0]}, 32'd5);
        take_result(0, 2, 32'h4120_0000, 16'd4, 1'b1);
      end
    join
    acc_sum[0] = 32'h4190_0000;
    send_word(0, 32'h40E0_0000, 1'b1);
    wait_result(0);
    check("t3b_mem0", mem[0][0], 32'd3);
    check("t3b_mem1", mem[0][1], 32'h40A0_0000);
    check("t3b_mem2", mem[0][2], 32'h40C0_0000);
    check("t3b_mem3", mem[0][3], 32'h40E0_0000);
    take_result(0, 0, 32'h4190_0000, 16'd3, 1'b0);

    // Single-word batch
    pulse_reset();
    acc_sum[0] = 32'hC0A0_0000;
    send_word(0, 32'hC0A0_0000, 1'b1);
    wait_result(0);
    check("t4_mem0", mem[0][0], 32'd1);
    check("t4_mem1", mem[0][1], 32'hC0A0_0000);
    check("t4_raddr", {16'd0, last_raddr[0]}, 32'd2);
    take_result(0, 0, 32'hC0A0_0000, 16'd1, 1'b0);

    // Reset while the accumulator runs
    pulse_reset();
    send_word(0, 32'h4000_0000, 1'b0);
    send_word(0, 32'h4040_0000, 1'b1);
    begin
      int n = 0;
      while (!(sel[0] && !acc_valid[0]) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("t5_reached_run", {31'd0, sel[0]}, 32'd1);
    end
    pulse_reset();
    check("t5_run_acc_valid", {31'd0, acc_valid[0]}, 32'd0);
    check("t5_run_sel", {31'd0, sel[0]}, 32'd0);
    check("t5_run_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("t5_run_busy", {31'd0, busy[0]}, 32'd0);

    // Reset after the second LOAD beat
    send_word(0, 32'h3F80_0000, 1'b0);
    send_word(0, 32'h3F80_0000, 1'b0);
    pulse_reset();
    check("t5_load_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("t5_load_busy", {31'd0, busy[0]}, 32'd0);
    check("t5_load_we", {31'd0, we[0]}, 32'd0);
    check("t5_load_acc_valid", {31'd0, acc_valid[0]}, 32'd0);

    // Fresh 2-word batch after the aborts: 2 + 3 = 5.0
    acc_sum[0] = 32'h40A0_0000;
    send_word(0, 32'h4000_0000, 1'b0);
    send_word(0, 32'h4040_0000, 1'b1);
    wait_result(0);
    check("t5_mem0", mem[0][0], 32'd2);
    take_result(0, 0, 32'h40A0_0000, 16'd2, 1'b0);

    // Relocated image at ADDR_BASE=0x100: 1 + 1 = 2.0
    acc_sum[1] = 32'h4000_0000;
    send_word(1, 32'h3F80_0000, 1'b0);
    send_word(1, 32'h3F80_0000, 1'b1);
    wait_result(1);
    check("t6_mem100", mem[1][9'h100], 32'd2);
    check("t6_mem101", mem[1][9'h101], 32'h3F80_0000);
    check("t6_mem102", mem[1][9'h102], 32'h3F80_0000);
    check("t6_raddr", {16'd0, last_raddr[1]}, 32'h0000_0103);
    take_result(1, 0, 32'h4000_0000, 16'd2, 1'b0);

    check("we_during_sel_a", {31'd0, we_sel_bad[0]}, 32'd0);
    check("we_during_sel_b", {31'd0, we_sel_bad[1]}, 32'd0);
    check("write_range_a", {31'd0, range_bad[0]}, 32'd0);
    check("write_range_b", {31'd0, range_bad[1]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
